// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Used by RTL checks and the bench so the fairness bound stays in one place.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Cycles within which a continuously requesting port must see its grant.
  function automatic int unsigned rr_bound(input int unsigned num_req,
                                           input int unsigned max_hold);
    return num_req * (max_hold + 2);
  endfunction

  // Hold counter width; at least one bit even when the hold limit is disabled.
  function automatic int unsigned hold_width(input int unsigned max_hold);
    return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// req/done/gnt handshake bundle between requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [IDW-1:0]     gnt_id;
  logic               preempt;

  modport master (output req, done, input gnt, gnt_valid, gnt_id, preempt);
  modport slave  (input req, done, output gnt, gnt_valid, gnt_id, preempt);
endinterface

// File: rtl/rr_grant_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [IDW-1:0] cand;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = IDW'((32'(ptr) + 32'(i)) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grants and an optional hold-limit preempt.
// Define HANDSHAKE_CHECKS_EN to compile the embedded handshake assertions.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  rr_grant_arbiter_if.slave  bus
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned HW  = hold_width(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               preempt_q, preempt_d;

  logic               pick_found;
  logic [IDW-1:0]     pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               rel_hs_c;
  logic               expire_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Handshake release takes precedence over hold expiry for the preempt pulse.
  assign rel_hs_c = bus.done[gnt_id_q] | ~bus.req[gnt_id_q];
  assign expire_c = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    preempt_d   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        hold_d   = '0;
        gnt_d    = '0;
        gnt_id_d = '0;
        if (pick_found) begin
          gnt_d    = pick_onehot;
          gnt_id_d = pick_idx;
          ptr_d    = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + IDW'(1);
          state_d  = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (rel_hs_c || expire_c) begin
          gnt_d     = '0;
          gnt_id_d  = '0;
          hold_d    = '0;
          state_d   = ARB_IDLE;
          preempt_d = ~rel_hs_c;
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.preempt   = preempt_q;

`ifdef HANDSHAKE_CHECKS_EN
  localparam int unsigned FAIR_BOUND = rr_bound(NUM_REQ, MAX_HOLD);

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
  a_valid:  assert property (@(posedge clk) disable iff (rst) bus.gnt_valid == |bus.gnt);
  a_done:   assert property (@(posedge clk) disable iff (rst)
                             bus.done[bus.gnt_id] && bus.gnt_valid |=> !bus.gnt_valid);
  a_pre:    assert property (@(posedge clk) disable iff (rst) bus.preempt |-> !bus.gnt_valid);
  c_pre:    cover property (@(posedge clk) disable iff (rst) bus.preempt);

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_req_chk
    m_hold_req: assume property (@(posedge clk) disable iff (rst)
                                 bus.req[i] && !bus.gnt[i] |=> bus.req[i]);
    c_gnt: cover property (@(posedge clk) disable iff (rst) bus.gnt[i]);
    if (MAX_HOLD != 0) begin : g_fair
      a_fair: assert property (@(posedge clk) disable iff (rst)
                               bus.req[i] |-> ##[1:FAIR_BOUND] bus.gnt[i]);
    end
  end
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Randomized and directed bench for rr_grant_arbiter against an integer-level reference model.
module tb_rr_grant_arbiter;
  import arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned MH = 8;
  localparam int unsigned FAIR = rr_bound(NR, MH);

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // reference model: owner index (-1 idle), next search start, cycles shown so far
  int   m_owner;
  int   m_ptr;
  int   m_held;
  bit   m_pre;
  int   waitc [NR];

  rr_grant_arbiter_if #(.NUM_REQ(NR)) bus ();

  rr_grant_arbiter #(.NUM_REQ(NR), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  c;
    bit  hit;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_pre = 1'b0;
    end else if (m_owner < 0) begin
      m_pre = 1'b0;
      hit   = 1'b0;
      for (int n = 0; n < int'(NR); n++) begin
        c = (m_ptr + n) % NR;
        if (!hit && bus.req[c]) begin
          hit = 1'b1; m_owner = c; m_ptr = (c + 1) % NR; m_held = 1;
        end
      end
    end else if (bus.done[m_owner] || !bus.req[m_owner]) begin
      m_owner = -1; m_held = 0; m_pre = 1'b0;
    end else if (MH != 0 && m_held == int'(MH)) begin
      m_owner = -1; m_held = 0; m_pre = 1'b1;
    end else begin
      m_held++;
      m_pre = 1'b0;
    end
  endtask

  // One clock: model follows the same sampled inputs, outputs compared 1ns later.
  task automatic step();
    logic [NR-1:0] eg;
    logic [NR-1:0] req_s;
    req_s = bus.req;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_owner < 0) ? '0 : NR'(1 << m_owner);
    check("gnt", 32'(bus.gnt), 32'(eg));
    check("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
    check("gnt_id", 32'(bus.gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("preempt", 32'(bus.preempt), 32'(m_pre));
    for (int i = 0; i < int'(NR); i++) begin
      if (rst) waitc[i] = 0;
      else if (m_owner == i) begin
        if (waitc[i] > 0) check("fair_wait_ok", 32'(waitc[i] <= int'(FAIR)), 32'd1);
        waitc[i] = 0;
      end else if (req_s[i]) waitc[i]++;
      else waitc[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.done = '0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int            order [5];
    int            n;
    int            guard;
    int            hi;
    bit            seen;
    bit            prev_v;
    logic [NR-1:0] req_v;
    logic [NR-1:0] done_v;

    n_checks = 0; n_fail = 0;
    m_owner = -1; m_ptr = 0; m_held = 0; m_pre = 1'b0;
    for (int i = 0; i < int'(NR); i++) waitc[i] = 0;
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1; bus.req = '0; bus.done = '0;

    // basic grant and done release
    do_reset();
    bus.req = 4'b0100;
    step();
    check("first_gnt", 32'(bus.gnt), 32'h4);
    check("first_id", 32'(bus.gnt_id), 32'd2);
    step(); step();
    bus.done = 4'b0100;
    step();
    bus.done = '0; bus.req = '0;
    check("done_release", 32'(bus.gnt), 32'h0);
    step(); step();

    // all requesting, holder releases after two grant cycles
    do_reset();
    bus.req = 4'b1111;
    n = 0; guard = 0; prev_v = 1'b0;
    while (n < 5 && guard < 60) begin
      bus.done = (m_owner >= 0 && m_held == 2) ? NR'(1 << m_owner) : '0;
      step();
      if (bus.gnt_valid && !prev_v) begin
        check("rr_order", 32'(bus.gnt_id), 32'(order[n]));
        n++;
      end
      prev_v = bus.gnt_valid;
      guard++;
    end
    check("rr_order_count", 32'(n), 32'd5);
    bus.req = '0; bus.done = '0;
    step(); step();

    // pure hold expiry
    do_reset();
    bus.req = 4'b0001;
    hi = 0; seen = 1'b0; guard = 0;
    while (!seen && guard < 20) begin
      step();
      if (bus.preempt) seen = 1'b1;
      else if (bus.gnt_valid) hi++;
      guard++;
    end
    check("hold_len", 32'(hi), 32'(MH));
    check("preempt_seen", 32'(seen), 32'd1);
    step();
    check("regrant_after_preempt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    step(); step();

    // done coinciding with hold expiry
    do_reset();
    bus.req = 4'b0010;
    step();
    guard = 0;
    while (m_held < int'(MH) && guard < 20) begin
      step();
      guard++;
    end
    check("reach_hold_last", 32'(m_held), 32'(MH));
    bus.done = 4'b0010;
    step();
    bus.done = '0;
    check("coincide_gnt", 32'(bus.gnt), 32'h0);
    check("coincide_preempt", 32'(bus.preempt), 32'd0);
    bus.req = '0;
    step(); step();

    // activity on non-granted bits
    do_reset();
    bus.req = 4'b1000;
    step();
    bus.req = 4'b1001; bus.done = 4'b0001;
    step();
    bus.done = '0;
    check("other_done_ignored", 32'(bus.gnt), 32'h8);
    step();
    check("other_req_ignored", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0001;
    step(); step();
    bus.req = '0;
    step(); step();

    // reset during a grant
    do_reset();
    bus.req = 4'b0010;
    step(); step();
    rst = 1'b1;
    step();
    check("rst_mid_gnt", 32'(bus.gnt), 32'h0);
    check("rst_mid_preempt", 32'(bus.preempt), 32'd0);
    rst = 1'b0;
    step();
    check("regrant_after_rst", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    step(); step();

    // randomized traffic honouring the hold-until-granted rule
    do_reset();
    req_v = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < int'(NR); i++) begin
        if (m_owner == i) req_v[i] = ($urandom_range(0, 7) != 0);
        else if (!req_v[i]) req_v[i] = ($urandom_range(0, 3) == 0);
      end
      done_v = NR'($urandom) & NR'($urandom);
      if (m_owner >= 0) done_v[m_owner] = ($urandom_range(0, 4) == 0);
      bus.req  = req_v;
      bus.done = done_v;
      rst = ($urandom_range(0, 299) == 0);
      if (rst) req_v = '0;
      step();
    end
    rst = 1'b0; bus.req = '0; bus.done = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
